landmark_assoc_seq: RTL and testbench
=====================================

// Module: landmark_assoc_seq
// PURPOSE
//  Data-association sequencer feeding the PLB state-vector mapper and consuming its assoc_status/assoc_l_k.
//  Per accepted observation it sweeps l_k = 1..lm_num, launching one association round per landmark.
//  After the sweep it samples the mapper's decision and emits an UPDATE / NEW / FAIL result.
//  It owns the map landmark count lm_num and holds l_k on the chosen landmark for the following NEW/UPD phase.
// PARAMETERS
//  ROW_LEN   10  width of landmark index / count
//  L_MAX     500 max landmarks in map (<= 2**ROW_LEN-2)
//  SETTLE    2   cycles from last assoc_done until assoc_status is valid
// PORTS
//  clk          in   1        system clock
//  sys_rst_n    in   1        reset, asynchronous, active-low
//  obs_valid    in   1        new observation available
//  obs_ready    out  1        high only in IDLE; accept = obs_valid & obs_ready
//  l_k          out  ROW_LEN  current landmark index to PLB mapper / association datapath
//  assoc_start  out  1        1-cycle pulse: launch one association round for l_k
//  assoc_done   in   1        1-cycle pulse: round finished (SEQ_11 of ASSOC_10 completed)
//  assoc_status in   2        00 WAIT, 01 NEW, 10 UPD, 11 FAIL (from mapper)
//  assoc_l_k    in   ROW_LEN  best-match landmark from mapper
//  res_valid    out  1        result valid; held until res_ready
//  res_ready    in   1        downstream accepts result
//  res_type     out  2        01 NEW, 10 UPD, 11 FAIL (00 when res_valid low)
//  res_l_k      out  ROW_LEN  landmark index for result (0 for FAIL)
//  lm_num       out  ROW_LEN  landmarks currently in map
//  lm_full      out  1        lm_num == L_MAX
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all outputs 0, lm_num=0; in-flight round abandoned, no result.
//  States: IDLE, START, WAIT, NEXT, SETTLE, DECIDE, OUT.
//  IDLE: obs_ready=1. On accept: lm_num==0 -> OUT with NEW, res_l_k=1; else l_k<=1, -> START.
//  START: assoc_start=1 for exactly this cycle, -> WAIT. l_k stable from START through NEXT.
//  WAIT: hold until assoc_done; assoc_done in any other state is ignored.
//  NEXT: l_k==lm_num -> SETTLE (counter=SETTLE); else l_k<=l_k+1, -> START. One idle cycle between rounds.
//  SETTLE: decrement counter; at 0 -> DECIDE. assoc_status is not sampled before DECIDE.
//  DECIDE (one cycle, registers result):
//   UPD  -> res_type=UPD, res_l_k=assoc_l_k (assoc_l_k==0 or >lm_num -> FAIL instead)
//   NEW  -> lm_full ? FAIL,res_l_k=0 : NEW, res_l_k=lm_num+1
//   FAIL or WAIT -> FAIL, res_l_k=0
//  OUT: res_valid=1, res_type/res_l_k stable; l_k driven = res_l_k (0 for FAIL) so the NEW/UPD phase
//   addresses the correct PLB slot. On res_valid&res_ready: if NEW, lm_num<=lm_num+1 (same edge);
//   res_valid<=0, res_type<=0, l_k<=0, -> IDLE. Earliest next accept: following cycle.
//  Latency (lm_num=N>0, assoc_done k cycles after each start): accept -> res_valid = N*(k+2)+SETTLE+2 cycles.
//  lm_num saturates at L_MAX; never increments on FAIL/UPD. res_l_k width never overflows (L_MAX bound).
//  obs_valid while busy: ignored (not accepted, obs_ready=0). assoc_done coincident with reset: reset wins.
// TESTING
//  T1 empty map: reset, obs_valid 1 cycle -> no assoc_start; res_valid NEW res_l_k=1; after res_ready lm_num=1.
//  T2 sweep/UPD: lm_num=3, done 4 cycles after each start -> assoc_start pulses with l_k=1,2,3; status=10,
//     assoc_l_k=2 -> res UPD res_l_k=2, l_k=2 in OUT, lm_num stays 3; latency = 3*6+4 = 22 cycles.
//  T3 NEW: lm_num=3, status=01 -> res NEW res_l_k=4; lm_num=4 on handshake edge, not before.
//  T4 full map: lm_num=L_MAX, status=01 -> res FAIL res_l_k=0, lm_num unchanged; status=11 -> FAIL.
//  T5 backpressure: res_ready low 5 cycles -> res_valid/res_type/res_l_k/l_k stable; obs_valid ignored.
//  T6 reset mid-WAIT (l_k=2): assert sys_rst_n=0 async -> outputs 0 immediately, lm_num=0, next obs takes T1 path.

Source files
------------

// File: rtl/landmark_assoc_seq.sv
// Data-association sequencer: sweeps l_k = 1..lm_num per observation,
// launches one association round each, then emits an UPD/NEW/FAIL result.
//
// Ports:
//   clk, sys_rst_n            clock, async active-low reset
//   obs_valid / obs_ready     observation handshake (ready only in IDLE)
//   l_k                       landmark index to the mapper datapath
//   assoc_start / assoc_done  per-landmark association round pulses
//   assoc_status, assoc_l_k   mapper decision and best-match index
//   res_valid / res_ready     result handshake; res_type, res_l_k payload
//   lm_num, lm_full           landmark count in map and full flag
module landmark_assoc_seq #(
    parameter int ROW_LEN = 10,
    parameter int L_MAX   = 500,
    parameter int SETTLE  = 2
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic               obs_valid,
    output logic               obs_ready,
    output logic [ROW_LEN-1:0] l_k,
    output logic               assoc_start,
    input  logic               assoc_done,
    input  logic [1:0]         assoc_status,
    input  logic [ROW_LEN-1:0] assoc_l_k,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [1:0]         res_type,
    output logic [ROW_LEN-1:0] res_l_k,
    output logic [ROW_LEN-1:0] lm_num,
    output logic               lm_full
);

    localparam logic [1:0] T_NEW  = 2'b01;
    localparam logic [1:0] T_UPD  = 2'b10;
    localparam logic [1:0] T_FAIL = 2'b11;
    localparam int CW = $clog2(SETTLE + 2);
    localparam logic [ROW_LEN-1:0] LMAX_W = ROW_LEN'(L_MAX);
    localparam logic [ROW_LEN-1:0] ONE_W  = ROW_LEN'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT, S_NEXT, S_SETTLE, S_DECIDE, S_OUT
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [ROW_LEN-1:0] r_l_k;
    logic               r_start;
    logic               r_res_valid;
    logic [1:0]         r_res_type;
    logic [ROW_LEN-1:0] r_res_l_k;
    logic [ROW_LEN-1:0] r_lm_num;

    logic               w_full;
    logic [1:0]         w_type;
    logic [ROW_LEN-1:0] w_lk;

    assign w_full = (r_lm_num == LMAX_W);

    // Mapper decision; only consumed in DECIDE. A best-match index outside
    // the current map is treated as a failed association.
    always_comb begin
        w_type = T_FAIL;
        w_lk   = '0;
        unique case (assoc_status)
            T_UPD: begin
                if (assoc_l_k != '0 && assoc_l_k <= r_lm_num) begin
                    w_type = T_UPD;
                    w_lk   = assoc_l_k;
                end
            end
            T_NEW: begin
                if (!w_full) begin
                    w_type = T_NEW;
                    w_lk   = r_lm_num + ONE_W;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_l_k       <= '0;
            r_start     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_type  <= 2'b00;
            r_res_l_k   <= '0;
            r_lm_num    <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (obs_valid) begin
                        if (r_lm_num == '0) begin
                            // Empty map: nothing to sweep, new landmark 1.
                            r_res_valid <= 1'b1;
                            r_res_type  <= T_NEW;
                            r_res_l_k   <= ONE_W;
                            r_l_k       <= ONE_W;
                            r_state     <= S_OUT;
                        end else begin
                            r_l_k   <= ONE_W;
                            r_start <= 1'b1;
                            r_state <= S_START;
                        end
                    end
                end
                S_START: r_state <= S_WAIT;
                S_WAIT: begin
                    if (assoc_done) r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_l_k == r_lm_num) begin
                        r_cnt   <= CW'(SETTLE);
                        r_state <= S_SETTLE;
                    end else begin
                        r_l_k   <= r_l_k + ONE_W;
                        r_start <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_SETTLE: begin
                    // Spends SETTLE cycles here before status is trusted.
                    if (r_cnt <= CW'(1)) r_state <= S_DECIDE;
                    else r_cnt <= r_cnt - CW'(1);
                end
                S_DECIDE: begin
                    r_res_valid <= 1'b1;
                    r_res_type  <= w_type;
                    r_res_l_k   <= w_lk;
                    r_l_k       <= w_lk;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (res_ready) begin
                        if (r_res_type == T_NEW && !w_full)
                            r_lm_num <= r_lm_num + ONE_W;
                        r_res_valid <= 1'b0;
                        r_res_type  <= 2'b00;
                        r_res_l_k   <= '0;
                        r_l_k       <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign obs_ready   = (r_state == S_IDLE);
    assign l_k         = r_l_k;
    assign assoc_start = r_start;
    assign res_valid   = r_res_valid;
    assign res_type    = r_res_type;
    assign res_l_k     = r_res_l_k;
    assign lm_num      = r_lm_num;
    assign lm_full     = w_full;

endmodule

// File: tb/tb_landmark_assoc_seq.sv
// Directed bench for landmark_assoc_seq with a small association
// responder; map capacity shrunk to 4 so the full-map case is reachable.
module tb_landmark_assoc_seq;

    localparam int RL = 10;
    localparam int LM = 4;

    logic          clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          obs_valid = 1'b0;
    logic          obs_ready;
    logic [RL-1:0] l_k;
    logic          assoc_start;
    logic          assoc_done = 1'b0;
    logic [1:0]    assoc_status = 2'b00;
    logic [RL-1:0] assoc_l_k = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [1:0]    res_type;
    logic [RL-1:0] res_l_k;
    logic [RL-1:0] lm_num;
    logic          lm_full;

    int total = 0;
    int bad = 0;
    int k_dly = 4;
    int starts[$];

    landmark_assoc_seq #(.ROW_LEN(RL), .L_MAX(LM), .SETTLE(2)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .obs_valid(obs_valid), .obs_ready(obs_ready),
        .l_k(l_k), .assoc_start(assoc_start), .assoc_done(assoc_done),
        .assoc_status(assoc_status), .assoc_l_k(assoc_l_k),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_type(res_type), .res_l_k(res_l_k),
        .lm_num(lm_num), .lm_full(lm_full)
    );

    always #5 clk = ~clk;

    // Mapper stand-in: done pulse is seen k_dly cycles after the start cycle.
    always begin
        @(negedge clk);
        if (assoc_start === 1'b1) begin
            starts.push_back(int'(l_k));
            repeat (k_dly) @(negedge clk);
            assoc_done = 1'b1;
            @(negedge clk);
            assoc_done = 1'b0;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the first negedge with
    // res_valid high. lat = cycles from the accept cycle.
    task automatic do_obs(output int lat);
        obs_valid = 1'b1;
        @(negedge clk);
        obs_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid) chk("res_timeout", 0, 1);
    endtask

    task automatic hshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic add_new(input int exp_lk);
        int lat;
        assoc_status = 2'b01;
        do_obs(lat);
        chk("grow_lk", int'(res_l_k), exp_lk);
        hshake();
    endtask

    initial begin
        int lat;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_start", int'(assoc_start), 0);
        chk("rst_lk", int'(l_k), 0);
        chk("rst_lm_num", int'(lm_num), 0);
        sys_rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", int'(obs_ready), 1);

        // T1: empty map
        starts.delete();
        do_obs(lat);
        chk("t1_lat", lat, 1);
        chk("t1_nostart", starts.size(), 0);
        chk("t1_type", int'(res_type), 1);
        chk("t1_res_lk", int'(res_l_k), 1);
        chk("t1_lk", int'(l_k), 1);
        chk("t1_lm_pre", int'(lm_num), 0);
        hshake();
        chk("t1_lm_post", int'(lm_num), 1);
        chk("t1_valid_off", int'(res_valid), 0);
        chk("t1_type_off", int'(res_type), 0);
        chk("t1_lk_off", int'(l_k), 0);

        add_new(2);
        add_new(3);
        chk("grow_lm", int'(lm_num), 3);

        // T2: sweep and UPD
        starts.delete();
        assoc_status = 2'b10;
        assoc_l_k = 10'd2;
        do_obs(lat);
        chk("t2_lat", lat, 22);
        chk("t2_nstart", starts.size(), 3);
        n = starts.size();
        for (int i = 0; i < n; i++) chk("t2_start_lk", starts[i], i + 1);
        chk("t2_type", int'(res_type), 2);
        chk("t2_res_lk", int'(res_l_k), 2);
        chk("t2_lk", int'(l_k), 2);
        hshake();
        chk("t2_lm", int'(lm_num), 3);

        // UPD with an index beyond the map degrades to FAIL
        assoc_l_k = 10'd5;
        do_obs(lat);
        chk("upd_oob_type", int'(res_type), 3);
        chk("upd_oob_lk", int'(res_l_k), 0);
        hshake();
        assoc_l_k = 10'd0;
        do_obs(lat);
        chk("upd_zero_type", int'(res_type), 3);
        hshake();

        // T3: NEW on a 3-landmark map
        assoc_status = 2'b01;
        do_obs(lat);
        chk("t3_type", int'(res_type), 1);
        chk("t3_res_lk", int'(res_l_k), 4);
        chk("t3_lk", int'(l_k), 4);
        chk("t3_lm_pre", int'(lm_num), 3);
        hshake();
        chk("t3_lm_post", int'(lm_num), 4);
        chk("t3_full", int'(lm_full), 1);

        // T4: full map
        do_obs(lat);
        chk("t4_new_type", int'(res_type), 3);
        chk("t4_new_lk", int'(res_l_k), 0);
        hshake();
        chk("t4_lm", int'(lm_num), 4);
        assoc_status = 2'b11;
        do_obs(lat);
        chk("t4_fail_type", int'(res_type), 3);
        hshake();
        assoc_status = 2'b00;
        do_obs(lat);
        chk("t4_wait_type", int'(res_type), 3);
        hshake();
        chk("t4_lm_end", int'(lm_num), 4);

        // T5: backpressure, obs_valid ignored while busy
        assoc_status = 2'b10;
        assoc_l_k = 10'd1;
        do_obs(lat);
        obs_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_valid", int'(res_valid), 1);
            chk("t5_type", int'(res_type), 2);
            chk("t5_res_lk", int'(res_l_k), 1);
            chk("t5_lk", int'(l_k), 1);
            chk("t5_ready", int'(obs_ready), 0);
        end
        obs_valid = 1'b0;
        hshake();
        chk("t5_lm", int'(lm_num), 4);

        // T6: async reset during WAIT of landmark 2
        starts.delete();
        assoc_status = 2'b01;
        obs_valid = 1'b1;
        @(negedge clk);
        obs_valid = 1'b0;
        n = 0;
        while (starts.size() < 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("t6_reach", int'(starts.size() >= 2), 1);
        @(negedge clk);
        chk("t6_lk_pre", int'(l_k), 2);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("t6_lk", int'(l_k), 0);
        chk("t6_lm", int'(lm_num), 0);
        chk("t6_valid", int'(res_valid), 0);
        chk("t6_start", int'(assoc_start), 0);
        @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        starts.delete();
        do_obs(lat);
        chk("t6_lat", lat, 1);
        chk("t6_type", int'(res_type), 1);
        chk("t6_res_lk", int'(res_l_k), 1);
        chk("t6_nostart", starts.size(), 0);
        hshake();
        chk("t6_lm_post", int'(lm_num), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
